// File: rtl/sram_emu_pkg.sv
// Shared definitions for the SRAM bus emulator: data modes, LFSR constants
// and the single-step LFSR helper.
package sram_emu_pkg;

   localparam int CNT_W = 32;

   typedef enum logic [1:0] {
      MODE_CNT  = 2'd0,
      MODE_LFSR = 2'd1,
      MODE_MEM  = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   localparam logic [CNT_W-1:0] LFSR_SEED = 32'hACE1_0001;
   localparam logic [CNT_W-1:0] LFSR_TAPS = 32'h8020_0003;

   // Galois form, polynomial x^32 + x^22 + x^2 + x + 1, shifting right.
   function automatic logic [CNT_W-1:0] lfsr_step(input logic [CNT_W-1:0] state);
      return {1'b0, state[CNT_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
   endfunction

endpackage

// File: rtl/sram_emu_lat_pipe.sv
// Read-latency delay line for {valid, data, uninit}; idle stages carry zero
// data so the bus reads 0 whenever the output enable is low.
module sram_emu_lat_pipe #(
   parameter int W   = 8,
   parameter int LAT = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         rd_valid,
   input  logic [W-1:0] rd_data,
   input  logic         rd_uninit,
   output logic         dly_valid,
   output logic [W-1:0] dly_data,
   output logic         dly_uninit
);

   logic [LAT-1:0] valid_sr;
   logic [LAT-1:0] uninit_sr;
   logic [W-1:0]   data_sr [LAT];

   // Shift each read result one stage per clock; reset empties every stage.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         valid_sr  <= '0;
         uninit_sr <= '0;
         for (int i = 0; i < LAT; i++) data_sr[i] <= '0;
      end else begin
         valid_sr[0]  <= rd_valid;
         uninit_sr[0] <= rd_valid & rd_uninit;
         data_sr[0]   <= rd_valid ? rd_data : '0;
         for (int i = 1; i < LAT; i++) begin
            valid_sr[i]  <= valid_sr[i-1];
            uninit_sr[i] <= uninit_sr[i-1];
            data_sr[i]   <= data_sr[i-1];
         end
      end
   end

   assign dly_valid  = valid_sr[LAT-1];
   assign dly_uninit = uninit_sr[LAT-1];
   assign dly_data   = data_sr[LAT-1];

endmodule

// File: rtl/sram_emu.sv
// Asynchronous SRAM bus emulator with counter, LFSR and memory data modes.
// Optional uninitialised-read detection is enabled by SRAM_EMU_UNINIT_CHECK_EN.
module sram_emu
   import sram_emu_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 21,
   parameter int CS_N    = 4,
   parameter int DEPTH_W = 8,
   parameter int RD_LAT  = 1
) (
   input  logic              i_brd_clk,
   input  logic              i_reset_n,
   input  logic [CS_N-1:0]   i_sram_cs_n,
   input  logic              i_sram_read_n,
   input  logic              i_sram_write_n,
   input  logic [ADDR_W-1:0] i_sram_addr,
   input  logic [DATA_W-1:0] i_sram_wdata,
   output logic [DATA_W-1:0] o_sram_rdata,
   output logic              o_sram_rdata_oe,
   input  logic [1:0]        i_mode,
   input  logic              i_err_clr,
   output logic [15:0]       o_wr_count,
   output logic              o_err,
   output logic              o_uninit_rd
);

   localparam int DEPTH = 1 << DEPTH_W;

   mode_e             mode_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  lfsr_q;
   logic              wr_n_prev;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data;
   logic              rd_uninit;
   logic              pipe_uninit;

   logic [CS_N-1:0]    sel;
   logic [DEPTH_W-1:0] idx;
   logic               sel_valid;
   logic               err_now;
   logic               qual_rd;
   logic               wr_accept;

   assign sel       = ~i_sram_cs_n;
   assign idx       = i_sram_addr[DEPTH_W-1:0];
   assign sel_valid = $onehot(sel);
   assign err_now   = (!i_sram_read_n && !i_sram_write_n && (|sel))
                    || (!$onehot0(sel) && (!i_sram_read_n || !i_sram_write_n));
   assign qual_rd   = i_reset_n && sel_valid && !i_sram_read_n && i_sram_write_n;
   assign wr_accept = i_reset_n && sel_valid && i_sram_read_n && !i_sram_write_n && wr_n_prev;

   // Mode and previous write strobe are sampled every clock, reset included,
   // so a strobe held low across reset release is not seen as a new edge.
   always_ff @(posedge i_brd_clk) begin
      mode_q    <= mode_e'(i_mode);
      wr_n_prev <= i_sram_write_n;
   end

   // Free-running counter source.
   always_ff @(posedge i_brd_clk) begin
      if (!i_reset_n) cnt_q <= '0;
      else            cnt_q <= cnt_q + 1'b1;
   end

   // LFSR source, stepping once per qualified read in LFSR mode.
   always_ff @(posedge i_brd_clk) begin
      if (!i_reset_n)                            lfsr_q <= LFSR_SEED;
      else if (qual_rd && (mode_q == MODE_LFSR)) lfsr_q <= lfsr_step(lfsr_q);
   end

   // Storage keeps its contents through reset; writes land in every mode.
   always_ff @(posedge i_brd_clk) begin
      if (wr_accept) mem[idx] <= i_sram_wdata;
   end

   // Saturating count of accepted writes.
   always_ff @(posedge i_brd_clk) begin
      if (!i_reset_n)                              o_wr_count <= '0;
      else if (wr_accept && (o_wr_count != 16'hFFFF)) o_wr_count <= o_wr_count + 16'd1;
   end

   // Sticky protocol error; a new error beats a simultaneous clear.
   always_ff @(posedge i_brd_clk) begin
      if (!i_reset_n)     o_err <= 1'b0;
      else if (err_now)   o_err <= 1'b1;
      else if (i_err_clr) o_err <= 1'b0;
   end

   // Pick the read word for the current mode; reserved mode acts as counter.
   always_comb begin
      rd_data = cnt_q[DATA_W-1:0];
      case (mode_q)
         MODE_LFSR: rd_data = lfsr_q[DATA_W-1:0];
         MODE_MEM:  rd_data = mem[idx];
         default:   rd_data = cnt_q[DATA_W-1:0];
      endcase
   end

`ifdef SRAM_EMU_UNINIT_CHECK_EN
   logic [DEPTH-1:0] valid_q;

   // Track which words have ever been written since reset.
   always_ff @(posedge i_brd_clk) begin
      if (!i_reset_n)     valid_q      <= '0;
      else if (wr_accept) valid_q[idx] <= 1'b1;
   end

   assign rd_uninit   = qual_rd && (mode_q == MODE_MEM) && !valid_q[idx];
   assign o_uninit_rd = pipe_uninit;
`else
   logic unused_uninit;

   assign rd_uninit     = 1'b0;
   assign unused_uninit = pipe_uninit;
   assign o_uninit_rd   = 1'b0;
`endif

   generate
      if (ADDR_W > DEPTH_W) begin : g_addr_hi
         logic unused_addr_hi;
         assign unused_addr_hi = ^i_sram_addr[ADDR_W-1:DEPTH_W];
      end
   endgenerate

   sram_emu_lat_pipe #(
      .W   (DATA_W),
      .LAT (RD_LAT)
   ) u_lat_pipe (
      .clk        (i_brd_clk),
      .reset_n    (i_reset_n),
      .rd_valid   (qual_rd),
      .rd_data    (rd_data),
      .rd_uninit  (rd_uninit),
      .dly_valid  (o_sram_rdata_oe),
      .dly_data   (o_sram_rdata),
      .dly_uninit (pipe_uninit)
   );

endmodule
